// File: rtl/keypad_lock_ctrl_if.sv
// Decoded key-event bus from the keypad scanner to the lock controller.
interface keypad_lock_ctrl_if #(
  parameter int unsigned KEY_W = 4
);
  logic [KEY_W-1:0] key_val;
  logic             key_valid;

  modport master (output key_val, key_valid);
  modport slave  (input  key_val, key_valid);
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Password-lock controller: code entry, run-time reprogramming, auto-relock,
// entry timeout and failed-attempt lockout with alarm.
module keypad_lock_ctrl #(
  parameter int unsigned                 KEY_W          = 4,
  parameter int unsigned                 CODE_LEN       = 4,
  parameter logic [KEY_W*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter logic [KEY_W-1:0]            KEY_ENTER      = 4'hE,
  parameter logic [KEY_W-1:0]            KEY_CLEAR      = 4'hC,
  parameter logic [KEY_W-1:0]            KEY_PROG       = 4'hA,
  parameter int unsigned                 MAX_TRIES      = 3,
  parameter int unsigned                 UNLOCK_CYCLES  = 100,
  parameter int unsigned                 LOCKOUT_CYCLES = 1000,
  parameter int unsigned                 TIMEOUT_CYCLES = 500
) (
  input  logic                               clk,
  input  logic                               rst,
  keypad_lock_ctrl_if.slave                  key_if,
  output logic                               locked,
  output logic                               unlocked,
  output logic                               alarm,
  output logic                               bad_pulse,
  output logic                               prog_done,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt
);

  localparam int unsigned CW      = KEY_W * CODE_LEN;
  localparam int unsigned FW      = $clog2(MAX_TRIES + 1);
  localparam int unsigned DW      = $clog2(CODE_LEN + 1);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned IW      = $clog2(TIMEOUT_CYCLES + 1);

  if (KEY_ENTER == KEY_CLEAR || KEY_ENTER == KEY_PROG || KEY_CLEAR == KEY_PROG) begin : g_key_chk
    $error("keypad_lock_ctrl: ENTER, CLEAR and PROG key values must be distinct");
  end
  if (CODE_LEN == 0) begin : g_len_chk
    $error("keypad_lock_ctrl: CODE_LEN must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROG     = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   buf_q, buf_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            ovf_q, ovf_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            bad_d, prog_d, locked_d, unlocked_d, alarm_d;
  logic            clr_buf, push;

  logic is_enter, is_clear, is_prog, is_digit;
  logic idle_exp, entry_full, code_ok;

  assign is_enter   = key_if.key_valid && (key_if.key_val == KEY_ENTER);
  assign is_clear   = key_if.key_valid && (key_if.key_val == KEY_CLEAR);
  assign is_prog    = key_if.key_valid && (key_if.key_val == KEY_PROG);
  assign is_digit   = key_if.key_valid && !(is_enter || is_clear || is_prog);
  // Expiry is decided before looking at the key so it wins a same-cycle race.
  assign idle_exp   = (dcnt_q != '0) && (idle_q == IW'(TIMEOUT_CYCLES - 1));
  assign entry_full = (dcnt_q == DW'(CODE_LEN)) && !ovf_q;
  assign code_ok    = entry_full && (buf_q == code_q);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    ovf_d   = ovf_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    idle_d  = '0;
    bad_d   = 1'b0;
    prog_d  = 1'b0;
    clr_buf = 1'b0;
    push    = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        idle_d = key_if.key_valid ? '0 : idle_q + IW'(1);
        if (idle_exp) begin
          clr_buf = 1'b1;
        end else if (is_digit) begin
          push = 1'b1;
        end else if (is_enter && (dcnt_q != '0)) begin
          clr_buf = 1'b1;
          if (code_ok) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
            tmr_d   = '0;
          end else begin
            bad_d  = 1'b1;
            fail_d = fail_q + FW'(1);
            if (fail_q == FW'(MAX_TRIES - 1)) begin
              state_d = ST_LOCKOUT;
              tmr_d   = '0;
            end
          end
        end else if (is_clear) begin
          clr_buf = 1'b1;
        end
      end

      ST_UNLOCKED: begin
        if (tmr_q == TW'(UNLOCK_CYCLES - 1)) begin
          state_d = ST_ENTRY;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (is_clear) begin
            state_d = ST_ENTRY;
            tmr_d   = '0;
          end else if (is_prog) begin
            state_d = ST_PROG;
            clr_buf = 1'b1;
          end
        end
      end

      // Relock timer is frozen here; only a successful store restarts it.
      ST_PROG: begin
        idle_d = key_if.key_valid ? '0 : idle_q + IW'(1);
        if (idle_exp) begin
          clr_buf = 1'b1;
          state_d = ST_UNLOCKED;
        end else if (is_digit) begin
          push = 1'b1;
        end else if (is_enter) begin
          clr_buf = 1'b1;
          state_d = ST_UNLOCKED;
          if (entry_full) begin
            code_d = buf_q;
            prog_d = 1'b1;
            tmr_d  = '0;
          end else begin
            bad_d = 1'b1;
          end
        end else if (is_clear) begin
          clr_buf = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      default: state_d = ST_ENTRY;
    endcase

    if (push) begin
      if (dcnt_q == DW'(CODE_LEN)) begin
        ovf_d = 1'b1;
      end else begin
        buf_d  = CW'({buf_q, key_if.key_val});
        dcnt_d = dcnt_q + DW'(1);
      end
    end
    if (clr_buf) begin
      buf_d  = '0;
      dcnt_d = '0;
      ovf_d  = 1'b0;
    end
    if (dcnt_d == '0) begin
      idle_d = '0;
    end

    unlocked_d = (state_d == ST_UNLOCKED) || (state_d == ST_PROG);
    locked_d   = !unlocked_d;
    alarm_d    = (state_d == ST_LOCKOUT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_ENTRY;
      code_q    <= DEFAULT_CODE;
      buf_q     <= '0;
      dcnt_q    <= '0;
      ovf_q     <= 1'b0;
      fail_q    <= '0;
      tmr_q     <= '0;
      idle_q    <= '0;
      locked    <= 1'b1;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      bad_pulse <= 1'b0;
      prog_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      buf_q     <= buf_d;
      dcnt_q    <= dcnt_d;
      ovf_q     <= ovf_d;
      fail_q    <= fail_d;
      tmr_q     <= tmr_d;
      idle_q    <= idle_d;
      locked    <= locked_d;
      unlocked  <= unlocked_d;
      alarm     <= alarm_d;
      bad_pulse <= bad_d;
      prog_done <= prog_d;
    end
  end

  assign fail_cnt  = fail_q;
  assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random key traffic,
// all checked every cycle against a behavioural lock model.
module tb_keypad_lock_ctrl;

  localparam int CODE_LEN  = 4;
  localparam int MAX_TRIES = 3;
  localparam int UNLOCK    = 100;
  localparam int LOCKOUT   = 1000;
  localparam int TIMEOUT   = 500;
  localparam int K_ENTER   = 14;
  localparam int K_CLEAR   = 12;
  localparam int K_PROG    = 10;
  localparam int M_ENTRY   = 0;
  localparam int M_UNL     = 1;
  localparam int M_PROG    = 2;
  localparam int M_LOCK    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_lock_ctrl_if #(.KEY_W(4)) kif ();
  keypad_lock_ctrl_if #(.KEY_W(4)) kif6 ();

  logic       locked, unlocked, alarm, bad_pulse, prog_done;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;
  logic       locked6, unlocked6, alarm6, bad6, prog6;
  logic [1:0] fail6;
  logic [2:0] digit6;

  keypad_lock_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_if    (kif),
    .locked    (locked),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .bad_pulse (bad_pulse),
    .prog_done (prog_done),
    .fail_cnt  (fail_cnt),
    .digit_cnt (digit_cnt)
  );

  keypad_lock_ctrl #(
    .CODE_LEN     (6),
    .DEFAULT_CODE (24'h135792)
  ) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .key_if    (kif6),
    .locked    (locked6),
    .unlocked  (unlocked6),
    .alarm     (alarm6),
    .bad_pulse (bad6),
    .prog_done (prog6),
    .fail_cnt  (fail6),
    .digit_cnt (digit6)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: digit queues and countdowns of cycles remaining.
  int m_mode, m_fails, m_unl_left, m_lock_left, m_idle_left;
  bit m_ovf, m_bad, m_prog;
  int m_code[$];
  int m_ent[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_ENTRY;
    m_fails = 0;
    m_unl_left = 0;
    m_lock_left = 0;
    m_idle_left = 0;
    m_ovf = 0;
    m_bad = 0;
    m_prog = 0;
    m_ent.delete();
    m_code = '{1, 2, 3, 4};
  endfunction

  function automatic void clear_entry();
    m_ent.delete();
    m_ovf = 0;
  endfunction

  function automatic void add_digit(input int k);
    if (m_ent.size() == CODE_LEN) m_ovf = 1;
    else m_ent.push_back(k);
  endfunction

  function automatic bit entry_matches();
    if (m_ent.size() != CODE_LEN || m_ovf) return 0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_ent[i] != m_code[i]) return 0;
    return 1;
  endfunction

  function automatic void model_step(input bit v, input int k);
    bit is_e, is_c, is_p, is_d, expired;
    is_e = v && (k == K_ENTER);
    is_c = v && (k == K_CLEAR);
    is_p = v && (k == K_PROG);
    is_d = v && !(is_e || is_c || is_p);
    m_bad = 0;
    m_prog = 0;
    if (rst == 1'b0) begin
      model_reset();
      return;
    end
    expired = (m_ent.size() > 0) && (m_idle_left == 1);
    if ((m_mode == M_ENTRY || m_mode == M_PROG) && !expired) begin
      if (v) m_idle_left = TIMEOUT;
      else if (m_ent.size() > 0) m_idle_left--;
    end
    case (m_mode)
      M_ENTRY: begin
        if (expired) clear_entry();
        else if (is_d) add_digit(k);
        else if (is_e && m_ent.size() > 0) begin
          if (entry_matches()) begin
            m_mode = M_UNL;
            m_fails = 0;
            m_unl_left = UNLOCK;
          end else begin
            m_bad = 1;
            m_fails++;
            if (m_fails == MAX_TRIES) begin
              m_mode = M_LOCK;
              m_lock_left = LOCKOUT;
            end
          end
          clear_entry();
        end else if (is_c) clear_entry();
      end
      M_UNL: begin
        if (m_unl_left == 1) m_mode = M_ENTRY;
        else begin
          m_unl_left--;
          if (is_c) m_mode = M_ENTRY;
          else if (is_p) begin
            m_mode = M_PROG;
            clear_entry();
          end
        end
      end
      M_PROG: begin
        if (expired) begin
          clear_entry();
          m_mode = M_UNL;
        end else if (is_d) add_digit(k);
        else if (is_e) begin
          if (m_ent.size() == CODE_LEN && !m_ovf) begin
            m_code = m_ent;
            m_prog = 1;
            m_unl_left = UNLOCK;
          end else m_bad = 1;
          clear_entry();
          m_mode = M_UNL;
        end else if (is_c) begin
          clear_entry();
          m_mode = M_UNL;
        end
      end
      default: begin
        if (m_lock_left == 1) begin
          m_mode = M_ENTRY;
          m_fails = 0;
        end else m_lock_left--;
      end
    endcase
  endfunction

  // One clock: drive main-DUT key, step model at the edge, compare after it.
  task automatic tick(input bit v, input int k);
    kif.key_valid = v;
    kif.key_val   = 4'(k);
    @(posedge clk);
    model_step(v, k);
    #1;
    check("locked",    int'(locked),    int'(m_mode == M_ENTRY || m_mode == M_LOCK));
    check("unlocked",  int'(unlocked),  int'(m_mode == M_UNL || m_mode == M_PROG));
    check("alarm",     int'(alarm),     int'(m_mode == M_LOCK));
    check("bad_pulse", int'(bad_pulse), int'(m_bad));
    check("prog_done", int'(prog_done), int'(m_prog));
    check("fail_cnt",  int'(fail_cnt),  m_fails);
    check("digit_cnt", int'(digit_cnt), m_ent.size());
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) tick(1, int'(v[(n-1-i)*4 +: 4]));
  endtask

  task automatic send6(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      kif6.key_valid = 1'b1;
      kif6.key_val   = v[(n-1-i)*4 +: 4];
      tick(0, 0);
      kif6.key_valid = 1'b0;
    end
  endtask

  task automatic press_gap(input int k);
    tick(1, k);
    repeat ($urandom_range(0, 2)) tick(0, 0);
  endtask

  initial begin
    int n;
    int cq[$];
    rst = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_val = '0;
    kif6.key_valid = 1'b0;
    kif6.key_val = '0;
    model_reset();
    @(negedge clk);
    tick(0, 0);
    tick(0, 0);
    rst = 1'b1;
    check("rst_locked", int'(locked), 1);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_fail", int'(fail_cnt), 0);
    check("rst_digits", int'(digit_cnt), 0);

    // Unlock with default code, then auto-relock
    send(32'h1234E, 5);
    check("unlock_1234", int'(unlocked), 1);
    check("unlock_not_locked", int'(locked), 0);
    idle(UNLOCK - 1);
    check("still_unlocked", int'(unlocked), 1);
    idle(1);
    check("auto_relock", int'(locked), 1);

    // Three bad attempts into lockout
    for (int i = 1; i <= 3; i++) begin
      send(32'h1235E, 5);
      check("bad_attempt_pulse", int'(bad_pulse), 1);
      check("bad_attempt_fails", int'(fail_cnt), i);
    end
    check("alarm_on", int'(alarm), 1);
    send(32'h1234E, 5);
    check("lockout_ignores_key", int'(unlocked), 0);
    idle(LOCKOUT - 6);
    check("alarm_held", int'(alarm), 1);
    idle(1);
    check("alarm_off", int'(alarm), 0);
    check("lockout_fail_clr", int'(fail_cnt), 0);

    // Reprogram to 9876
    send(32'h1234E, 5);
    send(32'hA9876E, 6);
    check("prog_done_pulse", int'(prog_done), 1);
    check("prog_keeps_unlocked", int'(unlocked), 1);
    send(32'hC, 1);
    check("clear_relocks", int'(locked), 1);
    send(32'h1234E, 5);
    check("old_code_rejected", int'(bad_pulse), 1);
    send(32'h9876E, 5);
    check("new_code_accepted", int'(unlocked), 1);

    // Reset in the middle of programming restores the default code
    send(32'hA1, 2);
    rst = 1'b0;
    tick(0, 0);
    rst = 1'b1;
    check("prst_locked", int'(locked), 1);
    check("prst_unlocked", int'(unlocked), 0);
    check("prst_digits", int'(digit_cnt), 0);
    send(32'h1234E, 5);
    check("default_restored", int'(unlocked), 1);
    send(32'hC, 1);

    // Entry timeout, overflow, mid-entry clear
    send(32'h12, 2);
    idle(TIMEOUT - 1);
    check("partial_held", int'(digit_cnt), 2);
    idle(1);
    check("partial_timeout", int'(digit_cnt), 0);
    check("timeout_no_fail", int'(fail_cnt), 0);
    send(32'h1234E, 5);
    check("unlock_after_timeout", int'(unlocked), 1);
    send(32'hC, 1);
    send(32'h12345E, 6);
    check("overflow_bad", int'(bad_pulse), 1);
    check("overflow_fail", int'(fail_cnt), 1);
    send(32'h12C, 3);
    check("clear_mid_entry", int'(digit_cnt), 0);
    check("clear_no_fail", int'(fail_cnt), 1);

    // Random key traffic against the model
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          cq = m_code;
          foreach (cq[j]) press_gap(cq[j]);
          press_gap(K_ENTER);
        end
        2: begin
          n = $urandom_range(1, 6);
          repeat (n) press_gap($urandom_range(0, 9));
          press_gap(K_ENTER);
        end
        3: press_gap(K_CLEAR);
        4: begin
          press_gap(K_PROG);
          n = $urandom_range(3, 5);
          repeat (n) press_gap($urandom_range(0, 9));
          press_gap(K_ENTER);
        end
        5: press_gap($urandom_range(0, 15));
        6: idle($urandom_range(1, 40));
        default: idle($urandom_range(90, 520));
      endcase
    end

    // Six-digit instance
    rst = 1'b0;
    tick(0, 0);
    rst = 1'b1;
    check("d6_rst_digits", int'(digit6), 0);
    check("d6_rst_alarm", int'(alarm6), 0);
    send6(32'h135792E, 7);
    check("d6_unlock", int'(unlocked6), 1);
    check("d6_no_prog", int'(prog6), 0);
    send6(32'hC, 1);
    check("d6_relock", int'(locked6), 1);
    send6(32'h13579E, 6);
    check("d6_short_bad", int'(bad6), 1);
    check("d6_short_fail", int'(fail6), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
